// File: rtl/keypad_pkg.sv
// Shared key codes and the entry FSM state type for the keypad entry controller.
package keypad_pkg;

    localparam logic [3:0] KEY_BKSP   = 4'hA;
    localparam logic [3:0] KEY_COMMIT = 4'hB;
    localparam logic [3:0] KEY_IGNORE = 4'hC;
    localparam logic [3:0] KEY_CLEAR  = 4'hD;
    localparam logic [3:0] KEY_NEXT   = 4'hE;
    localparam logic [3:0] KEY_IDLE   = 4'hF;

    typedef enum logic [1:0] {
        StEntry = 2'd0,
        StWait  = 2'd1,
        StDone  = 2'd2
    } entry_state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/key_press_detect.sv
// Press detector: one-cycle key_event for the first non-idle sample that follows
// IDLE_SAMPLES consecutive idle samples; a held key yields a single event.
module key_press_detect
    import keypad_pkg::*;
#(
    parameter int unsigned IDLE_SAMPLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_code,
    output logic       key_event
);

    // One bit per past sample, set when that sample was idle
    logic [IDLE_SAMPLES-1:0] idle_hist_q;
    logic                    key_event_q;
    logic                    sample_idle;

    assign sample_idle = (key_code == KEY_IDLE);

    // Shift in the idle flag each cycle and flag a fresh press
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_hist_q <= '1;
            key_event_q <= 1'b0;
        end else begin
            key_event_q <= !sample_idle && (&idle_hist_q);
            idle_hist_q <= IDLE_SAMPLES'({idle_hist_q, sample_idle});
        end
    end

    assign key_event = key_event_q;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: collects BCD operands from scanner key codes, with a
// hold-off period after every accepted key and a commit/done state.
module keypad_entry_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned NUM_OPERANDS = 2,
    parameter int unsigned WAIT_CYCLES  = 17_550_000,
    parameter int unsigned IDLE_SAMPLES = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [3:0]                         key_code,
    output logic [NUM_OPERANDS*NUM_DIGITS*4-1:0] operands,
    output logic [NUM_OPERANDS*4-1:0]          digit_cnt,
    output logic [1:0]                         active_idx,
    output logic                               busy,
    output logic                               done,
    output logic                               overflow,
    output logic [15:0]                        disp_data
);

    localparam int unsigned OP_W  = NUM_DIGITS * 4;
    localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);

    entry_state_t                     state_q;
    entry_state_t                     ret_q;
    logic [NUM_OPERANDS*OP_W-1:0]     ops_q;
    logic [NUM_OPERANDS*4-1:0]        cnt_q;
    logic [1:0]                       idx_q;
    logic                             busy_q;
    logic                             done_q;
    logic                             overflow_q;
    logic [CNT_W-1:0]                 wait_cnt_q;
    logic [3:0]                       key_q;
    logic                             key_event;

    logic [OP_W-1:0]                  cur_op;
    logic [3:0]                       cur_cnt;
    logic [OP_W-1:0]                  op_push;
    logic [OP_W-1:0]                  op_pop;
    logic [1:0]                       idx_next;
    logic [OP_W+11:0]                 disp_pad;

    key_press_detect #(
        .IDLE_SAMPLES(IDLE_SAMPLES)
    ) u_press (
        .clk      (clk),
        .rst      (rst),
        .key_code (key_code),
        .key_event(key_event)
    );

    // Delay the key code so it lines up with the registered key_event
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q <= KEY_IDLE;
        end else begin
            key_q <= key_code;
        end
    end

    // Select the active operand and precompute its edited forms
    always_comb begin
        cur_op  = '1;
        cur_cnt = '0;
        for (int k = 0; k < int'(NUM_OPERANDS); k++) begin
            if (idx_q == 2'(k)) begin
                cur_op  = ops_q[k*OP_W +: OP_W];
                cur_cnt = cnt_q[k*4 +: 4];
            end
        end
        op_push  = OP_W'({cur_op, key_q});
        op_pop   = OP_W'(cur_op >> 4) | (OP_W'(4'hF) << (OP_W - 4));
        idx_next = (idx_q == 2'(NUM_OPERANDS - 1)) ? 2'd0 : idx_q + 2'd1;
    end

    // Entry FSM with registered outputs and all operand storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StEntry;
            ret_q      <= StEntry;
            ops_q      <= '1;
            cnt_q      <= '0;
            idx_q      <= 2'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            overflow_q <= 1'b0;
            case (state_q)
                StEntry: begin
                    if (key_event) begin
                        if (is_digit(key_q)) begin
                            if (cur_cnt < 4'(NUM_DIGITS)) begin
                                for (int k = 0; k < int'(NUM_OPERANDS); k++) begin
                                    if (idx_q == 2'(k)) begin
                                        ops_q[k*OP_W +: OP_W] <= op_push;
                                        cnt_q[k*4 +: 4]       <= cur_cnt + 4'd1;
                                    end
                                end
                                state_q <= StWait;
                                ret_q   <= StEntry;
                                busy_q  <= 1'b1;
                            end else begin
                                overflow_q <= 1'b1;
                            end
                        end else begin
                            case (key_q)
                                KEY_BKSP: begin
                                    if (cur_cnt != 4'd0) begin
                                        for (int k = 0; k < int'(NUM_OPERANDS); k++) begin
                                            if (idx_q == 2'(k)) begin
                                                ops_q[k*OP_W +: OP_W] <= op_pop;
                                                cnt_q[k*4 +: 4]       <= cur_cnt - 4'd1;
                                            end
                                        end
                                        state_q <= StWait;
                                        ret_q   <= StEntry;
                                        busy_q  <= 1'b1;
                                    end
                                end
                                KEY_COMMIT: begin
                                    state_q <= StWait;
                                    ret_q   <= StDone;
                                    busy_q  <= 1'b1;
                                end
                                KEY_CLEAR: begin
                                    ops_q   <= '1;
                                    cnt_q   <= '0;
                                    idx_q   <= 2'd0;
                                    state_q <= StWait;
                                    ret_q   <= StEntry;
                                    busy_q  <= 1'b1;
                                end
                                KEY_NEXT: begin
                                    idx_q   <= idx_next;
                                    state_q <= StWait;
                                    ret_q   <= StEntry;
                                    busy_q  <= 1'b1;
                                end
                                default: ; // KEY_IGNORE and idle do nothing
                            endcase
                        end
                    end
                end
                StWait: begin
                    // Key events arriving here are dropped on purpose
                    if (wait_cnt_q == WAIT_LAST) begin
                        wait_cnt_q <= '0;
                        state_q    <= ret_q;
                        busy_q     <= 1'b0;
                        done_q     <= (ret_q == StDone);
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    if (key_event && key_q == KEY_CLEAR) begin
                        ops_q   <= '1;
                        cnt_q   <= '0;
                        idx_q   <= 2'd0;
                        state_q <= StWait;
                        ret_q   <= StEntry;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StEntry;
                end
            endcase
        end
    end

    // Display: operand tag then three low digits; missing positions read F
    always_comb begin
        disp_pad  = {12'hFFF, cur_op};
        disp_data = {4'hA + {2'b00, idx_q}, disp_pad[11:0]};
    end

    assign operands   = ops_q;
    assign digit_cnt  = cnt_q;
    assign active_idx = idx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Randomized and directed bench for keypad_entry_ctrl with a queue-based reference model.
module tb_keypad_entry_ctrl;

    localparam int ND = 4;
    localparam int NO = 2;
    localparam int WC = 8;
    localparam int IS = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [3:0]       key_code = 4'hF;
    logic [NO*ND*4-1:0] operands;
    logic [NO*4-1:0]  digit_cnt;
    logic [1:0]       active_idx;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [15:0]      disp_data;

    int checks   = 0;
    int failures = 0;

    // Reference model state: digits entered per operand, oldest first
    int dq [NO][$];
    int m_idx, m_mode, m_wait, m_ret, m_idle, m_ev_key;
    bit m_ev, m_ovf;
    int busy_acc, ovf_acc;

    keypad_entry_ctrl #(
        .NUM_DIGITS  (ND),
        .NUM_OPERANDS(NO),
        .WAIT_CYCLES (WC),
        .IDLE_SAMPLES(IS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_code  (key_code),
        .operands  (operands),
        .digit_cnt (digit_cnt),
        .active_idx(active_idx),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .disp_data (disp_data)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [ND*4-1:0] op_val(input int o);
        logic [ND*4-1:0] v;
        int n;
        n = dq[o].size();
        v = '1;
        for (int i = 0; i < ND; i++) begin
            if (i < n) v[i*4 +: 4] = 4'(dq[o][n-1-i]);
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int o = 0; o < NO; o++) dq[o].delete();
        m_idx = 0; m_mode = 0; m_wait = 0; m_ret = 0;
        m_idle = IS; m_ev = 0; m_ev_key = 15; m_ovf = 0;
    endtask

    task automatic model_clear();
        for (int o = 0; o < NO; o++) dq[o].delete();
        m_idx = 0;
    endtask

    task automatic enter_wait(input int r);
        m_mode = 1; m_wait = WC; m_ret = r;
    endtask

    // One clock edge of the behavioural model, k is the sample taken at that edge
    task automatic model_step(input int k);
        m_ovf = 0;
        if (m_mode == 1) begin
            m_wait--;
            if (m_wait == 0) m_mode = m_ret;
        end else if (m_ev) begin
            if (m_mode == 0) begin
                if (m_ev_key <= 9) begin
                    if (dq[m_idx].size() < ND) begin
                        dq[m_idx].push_back(m_ev_key);
                        enter_wait(0);
                    end else begin
                        m_ovf = 1;
                    end
                end else if (m_ev_key == 10) begin
                    if (dq[m_idx].size() > 0) begin
                        void'(dq[m_idx].pop_back());
                        enter_wait(0);
                    end
                end else if (m_ev_key == 11) begin
                    enter_wait(2);
                end else if (m_ev_key == 13) begin
                    model_clear();
                    enter_wait(0);
                end else if (m_ev_key == 14) begin
                    m_idx = (m_idx + 1) % NO;
                    enter_wait(0);
                end
            end else if (m_mode == 2 && m_ev_key == 13) begin
                model_clear();
                enter_wait(0);
            end
        end
        m_ev     = (k != 15) && (m_idle >= IS);
        m_ev_key = k;
        m_idle   = (k == 15) ? ((m_idle + 1 > IS) ? IS : m_idle + 1) : 0;
    endtask

    task automatic compare_all();
        logic [NO*ND*4-1:0] exp_ops;
        logic [NO*4-1:0]    exp_cnt;
        logic [ND*4+11:0]   pad;
        for (int o = 0; o < NO; o++) begin
            exp_ops[o*ND*4 +: ND*4] = op_val(o);
            exp_cnt[o*4 +: 4]       = 4'(dq[o].size());
        end
        pad = {12'hFFF, op_val(m_idx)};
        check_value("operands", 32'(operands), 32'(exp_ops));
        check_value("digit_cnt", 32'(digit_cnt), 32'(exp_cnt));
        check_value("active_idx", 32'(active_idx), 32'(m_idx));
        check_value("busy", 32'(busy), 32'(m_mode == 1));
        check_value("done", 32'(done), 32'(m_mode == 2));
        check_value("overflow", 32'(overflow), 32'(m_ovf));
        check_value("disp_data", 32'(disp_data), {16'h0, 4'(4'hA + m_idx), pad[11:0]});
    endtask

    // Compare at the falling edge, then drive the next sample and advance the model
    task automatic cycle(input logic [3:0] k);
        @(negedge clk);
        compare_all();
        busy_acc += int'(busy);
        ovf_acc  += int'(overflow);
        key_code = k;
        if (rst) model_step(int'(k));
        else model_reset();
    endtask

    task automatic press(input logic [3:0] k, input int hold, input int gap);
        repeat (hold) cycle(k);
        repeat (gap) cycle(4'hF);
    endtask

    task automatic reset_pulse(input int len);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check_value("rst_operands", 32'(operands), 32'hFFFF_FFFF);
        check_value("rst_digit_cnt", 32'(digit_cnt), 32'h0);
        check_value("rst_active_idx", 32'(active_idx), 32'h0);
        check_value("rst_busy", 32'(busy), 32'h0);
        check_value("rst_done", 32'(done), 32'h0);
        check_value("rst_overflow", 32'(overflow), 32'h0);
        check_value("rst_disp", 32'(disp_data), 32'h0000_AFFF);
        repeat (len) cycle(4'hF);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (3) cycle(4'hF);
        check_value("reset_disp", 32'(disp_data), 32'h0000_AFFF);
        @(negedge clk);
        rst = 1'b1;

        // Digits 1,2,3 held long
        for (int d = 1; d <= 3; d++) begin
            busy_acc = 0;
            press(4'(d), 20, 4);
            check_value("busy_len", 32'(busy_acc), 32'd8);
        end
        check_value("op0_123", 32'(operands[15:0]), 32'hF123);
        check_value("cnt0_3", 32'(digit_cnt[3:0]), 32'd3);
        check_value("disp_123", 32'(disp_data), 32'hA123);

        // Fill and overflow
        press(4'h4, 3, 12);
        busy_acc = 0; ovf_acc = 0;
        press(4'h5, 3, 12);
        check_value("op0_1234", 32'(operands[15:0]), 32'h1234);
        check_value("ovf_once", 32'(ovf_acc), 32'd1);
        check_value("ovf_no_wait", 32'(busy_acc), 32'd0);

        // Clear, then 7 E 9 A
        press(4'hD, 3, 12);
        press(4'h7, 3, 12);
        press(4'hE, 3, 12);
        press(4'h9, 3, 12);
        press(4'hA, 3, 12);
        check_value("idx_1", 32'(active_idx), 32'd1);
        check_value("op1_empty", 32'(operands[31:16]), 32'hFFFF);
        check_value("op0_7", 32'(operands[15:0]), 32'hFFF7);
        busy_acc = 0;
        press(4'hA, 3, 12);
        check_value("bksp_empty_nowait", 32'(busy_acc), 32'd0);

        // Second press landing inside WAIT
        busy_acc = 0;
        press(4'h2, 2, 2);
        press(4'h3, 2, 12);
        check_value("wait_len_kept", 32'(busy_acc), 32'd8);
        check_value("op1_2", 32'(operands[31:16]), 32'hFFF2);

        // Commit, ignored digit, clear from DONE
        press(4'hB, 3, 12);
        check_value("done_set", 32'(done), 32'd1);
        busy_acc = 0;
        press(4'h5, 3, 12);
        check_value("done_ignore", 32'(busy_acc), 32'd0);
        check_value("done_ops_kept", 32'(operands[31:16]), 32'hFFF2);
        press(4'hD, 3, 12);
        check_value("done_clear_ops", 32'(operands), 32'hFFFF_FFFF);
        check_value("done_cleared", 32'(done), 32'd0);
        check_value("back_entry", 32'(busy), 32'd0);

        // Reset in the middle of WAIT
        press(4'h4, 4, 0);
        check_value("in_wait", 32'(busy), 32'd1);
        reset_pulse(2);

        // Random phase
        for (int n = 0; n < 160; n++) begin
            int r;
            logic [3:0] k;
            r = int'($urandom_range(0, 19));
            k = (r < 12) ? 4'(r % 10) : 4'(10 + (r - 12) % 6);
            press(k, int'($urandom_range(1, 10)), int'($urandom_range(0, 5)));
            if ($urandom_range(0, 40) == 0) reset_pulse(int'($urandom_range(0, 2)));
        end
        repeat (12) cycle(4'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_entry_ctrl.md
KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, giving BCD digits per operand (range 1..8).
REQ-002 The block SHALL have parameter NUM_OPERANDS, default 2, giving operand register count (range 1..4).
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 17_550_000, giving the hold-off length after each accepted key (about 650 ms at 27 MHz).
REQ-004 The block SHALL have parameter IDLE_SAMPLES, default 2, giving the consecutive idle samples required before a press is recognised.
REQ-005 The block SHALL have port clk, input, 1 bit: 27 MHz clock.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port key_code, input, 4 bits: scanner output; 4'hF means idle.
REQ-008 The block SHALL have port operands, output, NUM_OPERANDS*NUM_DIGITS*4 bits: operand k occupies slice [k*NUM_DIGITS*4 +: NUM_DIGITS*4], least significant digit lowest.
REQ-009 The block SHALL have port digit_cnt, output, NUM_OPERANDS*4 bits: digits held per operand.
REQ-010 The block SHALL have port active_idx, output, 2 bits: operand currently being edited.
REQ-011 The block SHALL have port busy, output, 1 bit: high while in WAIT.
REQ-012 The block SHALL have port done, output, 1 bit: high while in DONE.
REQ-013 The block SHALL have port overflow, output, 1 bit: one-cycle pulse when a digit is rejected.
REQ-014 The block SHALL have port disp_data, output, 16 bits: display word, nibbles ordered left to right.

Function
REQ-015 Key codes SHALL be: 0..9 digit; A backspace; B commit; C ignored; D clear; E next operand; F idle.
REQ-016 key_event SHALL pulse for one cycle, one cycle after the first non-F sample that follows IDLE_SAMPLES consecutive F samples; holding a key SHALL produce exactly one event.
REQ-017 States SHALL be ENTRY, WAIT and DONE; reset state SHALL be ENTRY.
REQ-018 In ENTRY, an accepted key SHALL update registers and enter WAIT on the same edge that key_event is sampled high.
REQ-019 A digit, when digit_cnt of the active operand is below NUM_DIGITS, SHALL shift the operand left one digit, insert the new digit at the least significant position and increment digit_cnt.
REQ-020 A digit, when the active operand is full, SHALL leave registers unchanged, pulse overflow and stay in ENTRY (no WAIT).
REQ-021 Backspace SHALL shift the active operand right one digit, load 4'hF into the most significant digit and decrement digit_cnt; at digit_cnt 0 it SHALL be ignored with no WAIT.
REQ-022 Next-operand SHALL increment active_idx, wrapping from NUM_OPERANDS-1 to 0; with NUM_OPERANDS=1 active_idx SHALL stay 0 and WAIT still occurs.
REQ-023 Clear SHALL set every digit to 4'hF, every digit_cnt to 0 and active_idx to 0, then enter WAIT.
REQ-024 Commit SHALL enter WAIT with return target DONE; all other accepted keys SHALL return to ENTRY.
REQ-025 Code C SHALL be ignored in every state.
REQ-026 WAIT SHALL last exactly WAIT_CYCLES cycles and then move to the return target; key_events during WAIT SHALL be discarded.
REQ-027 In DONE, only Clear SHALL be accepted; it SHALL perform REQ-023 and return to ENTRY via WAIT.
REQ-028 disp_data SHALL be {4'hA + active_idx, the three least significant digits of the active operand}; digit positions at or above NUM_DIGITS SHALL read 4'hF.
REQ-029 The WAIT counter width SHALL be $clog2(WAIT_CYCLES+1), and the counter SHALL be zero outside WAIT.

Reset
REQ-030 Reset SHALL set: operands all 4'hF, digit_cnt 0, active_idx 0, busy 0, done 0, overflow 0, WAIT counter 0, idle history all F.
REQ-031 While rst is low, disp_data SHALL be 16'hAFFF.
REQ-032 Reset asserted mid-WAIT SHALL abort the WAIT immediately and return the block to ENTRY.

Structure
REQ-033 Package keypad_pkg SHALL hold the key-code localparams, the idle code and the entry_state_t enum.
REQ-034 Press detection SHALL be sub-module key_press_detect (parameter IDLE_SAMPLES; ports clk, rst, key_code, key_event).
REQ-035 The block SHALL contain no debouncing, scanning or 7-segment decoding.

Verification (bench WAIT_CYCLES=8)
REQ-036 Press 1, 2, 3 with each key held for 20 cycles -> operand0=16'hF123, digit_cnt0=3, disp_data=16'hA123; busy high for 8 cycles after each press.
REQ-037 Press 1, 2, 3, 4, 5 -> operand0=16'h1234 and overflow pulses once on the 5th press.
REQ-038 Press 7, E, 9, A -> active_idx=1, operand1=16'hFFFF, operand0=16'hFFF7; a second A is ignored and busy stays low.
REQ-039 Press a digit again at cycle 3 of WAIT -> no register change and WAIT duration unchanged.
REQ-040 Press B -> done=1 after 8 cycles; then digit 5 -> ignored; then D -> all operands F and the block returns to ENTRY.
REQ-041 Assert rst during WAIT -> all outputs equal their reset values on the same cycle.
